// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per cycle, sign fix-up,
// and results held until the downstream stage takes them. Owns the E-stage stall.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    input  logic             res_ready,
    output logic             div_stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH+1:0] trial;

    assign dvd_neg = signed_op & dividend[WIDTH-1];
    assign dsr_neg = signed_op & divisor[WIDTH-1];

    // quo_q starts as the dividend magnitude; its MSB feeds the partial remainder
    // while quotient bits shift in at the bottom.
    assign trial = {rem_q, quo_q[WIDTH-1]} - {2'b00, dsr_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        if (cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient_d  = '1;
                            remainder_d = dividend;
                            dbz_d       = 1'b1;
                            state_d     = DONE;
                        end else begin
                            quo_d     = dvd_neg ? -dividend : dividend;
                            dsr_d     = dsr_neg ? -divisor : divisor;
                            rem_d     = '0;
                            neg_quo_d = dvd_neg ^ dsr_neg;
                            neg_rem_d = dvd_neg;
                            cnt_d     = '0;
                            state_d   = CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[WIDTH+1]) begin
                        rem_d = trial[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    quotient_d  = neg_quo_q ? -quo_q : quo_q;
                    remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Stall drops in DONE so the instruction can leave E carrying its result.
    assign div_stall   = ((state_q == IDLE) && start && !cancel) ||
                         (state_q == CALC) || (state_q == FIX);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, stall window, signed/unsigned results,
// zero divisor, cancel, result hold and mid-operation reset.
module tb_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        res_ready;
    logic        div_stall;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .cancel      (cancel),
        .res_ready   (res_ready),
        .div_stall   (div_stall),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide from IDLE and wait (bounded) for done. lat is the cycle
    // index at which done is first seen (-1 on timeout); stall_ok records whether
    // div_stall was high in every cycle before done and low once done is seen.
    task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit stall_ok);
        signed_op = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        #1;
        stall_ok = (div_stall === 1'b1);
        tick();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (div_stall !== 1'b1) stall_ok = 1'b0;
            tick();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        else if (div_stall !== 1'b0) stall_ok = 1'b0;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (div_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b expected 0", div_stall); end
        checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient got %h expected 00000000", quotient); end
        checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL reset_remainder got %h expected 00000000", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b expected 0", div_by_zero); end
        reset = 1'b1;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_unsigned();
        int lat; bit sok;
        launch(1'b0, 32'd100, 32'd7, lat, sok);
        checks++; if (lat != 34) begin errors++; $display("FAIL udiv_latency got %0d expected 34", lat); end
        checks++; if (!sok) begin errors++; $display("FAIL udiv_stall_window got bad expected high 0..33 low at 34"); end
        checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL udiv_quotient got %0d expected 14", quotient); end
        checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL udiv_remainder got %0d expected 2", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL udiv_dbz got %b expected 0", div_by_zero); end
        $display("divu 100/7: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
        accept();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL udiv_release got done=%b busy=%b expected 0/0", done, busy); end
    endtask

    task automatic test_signed();
        int lat; bit sok;
        launch(1'b1, 32'hFFFF_FFF9, 32'h2, lat, sok);
        checks++; if (quotient !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_m7_q got %h expected fffffffd", quotient); end
        checks++; if (remainder !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_m7_r got %h expected ffffffff", remainder); end
        $display("div -7/2: q=%h r=%h", quotient, remainder);
        accept();
        // back-to-back: next start the cycle after DONE->IDLE
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, sok);
        checks++; if (lat != 34) begin errors++; $display("FAIL sdiv_b2b_latency got %0d expected 34", lat); end
        checks++; if (quotient !== 32'h8000_0000) begin errors++; $display("FAIL sdiv_min_q got %h expected 80000000", quotient); end
        checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL sdiv_min_r got %h expected 00000000", remainder); end
        $display("div 80000000/ffffffff: q=%h r=%h", quotient, remainder);
        accept();
        launch(1'b0, 32'hFFFF_FFFF, 32'h1, lat, sok);
        checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL udiv_max_q got %h expected ffffffff", quotient); end
        checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL udiv_max_r got %h expected 00000000", remainder); end
        $display("divu ffffffff/1: q=%h r=%h", quotient, remainder);
        accept();
    endtask

    task automatic test_div_zero();
        int lat; bit sok;
        launch(1'b0, 32'h1234, 32'h0, lat, sok);
        checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency got %0d expected 1", lat); end
        checks++; if (!sok) begin errors++; $display("FAIL dbz_stall_window got bad expected high only in cycle 0"); end
        checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_q got %h expected ffffffff", quotient); end
        checks++; if (remainder !== 32'h1234) begin errors++; $display("FAIL dbz_r got %h expected 00001234", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b expected 1", div_by_zero); end
        $display("divu 1234/0: lat=%0d q=%h r=%h dbz=%b", lat, quotient, remainder, div_by_zero);
        accept();
    endtask

    task automatic test_cancel();
        int lat; bit sok; bit saw_done;
        signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        cancel = 1'b1;
        start  = 1'b1;
        tick();
        cancel = 1'b0;
        start  = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b expected 0", busy); end
        checks++; if (div_stall !== 1'b0) begin errors++; $display("FAIL cancel_stall got %b expected 0", div_stall); end
        saw_done = 1'b0;
        repeat (40) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++; if (saw_done) begin errors++; $display("FAIL cancel_no_done got done=1 expected never"); end
        checks++; if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234 || div_by_zero !== 1'b1) begin
            errors++; $display("FAIL cancel_results_held got q=%h r=%h dbz=%b expected ffffffff 00001234 1", quotient, remainder, div_by_zero);
        end
        $display("cancel in CALC: busy=%b stall=%b", busy, div_stall);
        launch(1'b0, 32'd9, 32'd3, lat, sok);
        checks++; if (quotient !== 32'd3 || remainder !== 32'd0) begin
            errors++; $display("FAIL after_cancel_9_3 got q=%0d r=%0d expected 3 0", quotient, remainder);
        end
        $display("divu 9/3 after cancel: q=%0d r=%0d", quotient, remainder);
        accept();
    endtask

    task automatic test_hold();
        int lat; bit sok;
        launch(1'b1, 32'hFFFF_FF9C, 32'd7, lat, sok);   // -100 / 7
        start = 1'b1;                                   // must be ignored in DONE
        for (int i = 0; i < 5; i++) begin
            checks++; if (done !== 1'b1 || quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE) begin
                errors++; $display("FAIL hold_cycle%0d got done=%b q=%h r=%h expected 1 fffffff2 fffffffe", i, done, quotient, remainder);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL hold_release_start_ignored got busy=%b done=%b expected 0 0", busy, done); end
        $display("div -100/7 held 5 cycles: q=%h r=%h", quotient, remainder);
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || div_stall !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_ctrl got busy=%b stall=%b done=%b expected 0 0 0", busy, div_stall, done);
        end
        checks++; if (quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL midreset_results got q=%h r=%h dbz=%b expected 0 0 0", quotient, remainder, div_by_zero);
        end
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL midreset_no_done got done=1 expected never"); end
        $display("reset mid-CALC: busy=%b q=%h", busy, quotient);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        cancel = 1'b0; res_ready = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_cancel();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
